exp_fp32_result_packer: RTL

//  Downstream stage of the 128-bit fp32 exp core. It buffers result words from the fixed-latency

---
 rtl/exp_fp32_result_packer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/exp_fp32_result_packer.sv
// ----------------------------------------------------------------------------
// exp_fp32_result_packer
//
// Sits after the fixed-latency 128-bit fp32 exp core. The core has no stall
// input, so every launched word must have a free slot waiting for it. This
// block buffers core results in a FIFO and only grants issue credit while
// (words buffered + words still inside the core) < FIFO_DEPTH. It also frames
// the buffered words as an AXI4-Stream with TLAST every param_len beats for
// the DMA S2MM channel.
//
// Optional feature macro: EXP_PACKER_OVERFLOW_DET_EN
//   defined     : sticky overflow flag sets on a dropped write; simulation-only
//                 assertion flags issue while issue_ready is low.
//   not defined : overflow tied low; dropped writes are silently discarded.
//
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   start           pulse: latch param_len and open a frame (ignored while busy)
//   param_len       beats per frame (0 behaves as 1)
//   busy            frame in progress
//   done            one-cycle pulse after the TLAST beat is accepted
//   issue           upstream launched one word into the core this cycle
//   issue_ready     upstream may launch a word this cycle
//   s_valid/s_data  core result (no back-pressure, always written)
//   m_axis_*        AXI4-Stream master towards the DMA
//   overflow        sticky drop indicator
//   dbg_state       current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a beat transfers on a cycle where m_axis_tvalid and
// m_axis_tready are both high. Once tvalid is high it stays high, with tdata
// and tlast unchanged, until that transfer happens; only reset drops it.
// ----------------------------------------------------------------------------
module exp_fp32_result_packer #(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 32,
    parameter int CORE_LAT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  param_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  issue,
    output logic                  issue_ready,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overflow,
    output logic                  dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Extra headroom so protocol-violating over-issue does not wrap quickly.
    localparam int IW = AW + 4;

    // Elaboration-time sanity check on the configuration.
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CORE_LAT < 1) begin : g_bad_param
        $error("exp_fp32_result_packer: FIFO_DEPTH must be a power of two >= 4, CORE_LAT >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic                   done_q, done_d;
    logic                   issue_ready_q, issue_ready_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [IW-1:0]          inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   rd_en;
    logic                   wr_en;
    logic [31:0]            occupancy;

    // ------------------------------------------------------------------
    // FIFO datapath (first-word-fall-through head)
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty    = (count_q == '0);
        fifo_full     = (count_q == CW'(FIFO_DEPTH));
        m_axis_tvalid = (state_q == RUN) && !fifo_empty;
        m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
        // beat_cnt only moves on a transfer, so tlast is stable while stalled.
        m_axis_tlast  = m_axis_tvalid && (beat_cnt_q == (len_q - LEN_WIDTH'(1)));
        rd_en         = m_axis_tvalid && m_axis_tready;
        // Writing into a full FIFO is fine when the head leaves this cycle.
        wr_en         = s_valid && (!fifo_full || rd_en);

        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    // ------------------------------------------------------------------
    // Credit accounting
    // ------------------------------------------------------------------
    always_comb begin
        inflight_d = inflight_q;
        case ({issue, s_valid})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   if (inflight_q != '0) inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase
        // Evaluate on the post-update occupancy so that the credit withdrawn
        // by this cycle's issue is already visible next cycle.
        occupancy     = 32'(count_d) + 32'(inflight_d);
        issue_ready_d = (occupancy < 32'(FIFO_DEPTH));
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = (param_len == '0) ? LEN_WIDTH'(1) : param_len;
                    beat_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (rd_en) begin
                    if (m_axis_tlast) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            len_q         <= LEN_WIDTH'(1);
            beat_cnt_q    <= '0;
            done_q        <= 1'b0;
            issue_ready_q <= 1'b1;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            beat_cnt_q    <= beat_cnt_d;
            done_q        <= done_d;
            issue_ready_q <= issue_ready_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign issue_ready = issue_ready_q;
    assign dbg_state   = state_q;

    // ------------------------------------------------------------------
    // Overflow detection
    // ------------------------------------------------------------------
`ifdef EXP_PACKER_OVERFLOW_DET_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (s_valid && fifo_full && !rd_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    issue_without_credit_a : assert property (
        @(posedge clk) disable iff (reset) !(issue && !issue_ready_q)
    ) else $error("exp_fp32_result_packer: issue while issue_ready low");
`else
    assign overflow = 1'b0;
`endif

endmodule
